mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the core's I-cache and D-cache miss/writeback interfaces and a single-ported line memory. It sits between `core` and `memory` in `soc` and replaces their direct I/D wiring. It latches single-cycle request pulses into per-requester pending slots, serialises them onto one memory port using round-robin between the I and D sides, and returns registered, line-wide responses on the matching side.

## Interface
- `WORD_SIZE`, `WORD_SIZE` define (32); address width.
- `LINE_SIZE`, `CACHE_LINE_SIZE` define (128); data width of reads and writes.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`  in  1  one-cycle I-line read request pulse.
- `i_addr`  in  WORD_SIZE  I request address, sampled with `i_read`.
- `i_res`  out  1  one-cycle I response valid.
- `i_res_data`  out  LINE_SIZE  I response line.
- `i_res_addr`  out  WORD_SIZE  echoed I request address.
- `d_read`  in  1  one-cycle D-line read request pulse.
- `d_addr`  in  WORD_SIZE  D read address.
- `d_res`  out  1  one-cycle D read response valid.
- `d_res_data`  out  LINE_SIZE  D response line.
- `d_res_addr`  out  WORD_SIZE  echoed D read address.
- `d_wenable`  in  1  one-cycle D writeback request pulse.
- `d_w_data`  in  LINE_SIZE  writeback line.
- `d_w_addr`  in  WORD_SIZE  writeback address.
- `mem_req`  out  1  one-cycle memory command strobe.
- `mem_we`  out  1  command is a write; valid with `mem_req`.
- `mem_addr`  out  WORD_SIZE  command address.
- `mem_wdata`  out  LINE_SIZE  write line.
- `mem_res`  in  1  memory completion pulse for both reads and writes; arrives 1 or more cycles after `mem_req`.
- `mem_res_data`  in  LINE_SIZE  read line, valid with `mem_res`.

## Operation
- Three pending slots: IR (I read), DR (D read), DW (D write). Each holds a valid flag plus the latched address, and write data for DW.
  - A pulse sets its slot at the clock edge.
  - A pulse arriving while its slot is already valid is dropped. The caches never issue one.
  - If a pulse and the slot clear occur in the same cycle, the set wins.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if any slot is valid, select a winner, register the `mem_*` command with `mem_req`=1, and go to WAIT. Otherwise stay in IDLE. `mem_res` is ignored in IDLE.
  - WAIT: `mem_req`=0. On `mem_res`, register `mem_res_data` and go to RESP.
  - RESP: for the winner IR, drive `i_res`=1. For DR, drive `d_res`=1. For DW, raise no response. Clear the winner's slot and return to IDLE.
- Arbitration:
  - Round-robin between the I side and the D side, using flag `last_d`, which is updated on each grant.
  - Within the D side, DW always precedes DR, so a read never overtakes a writeback of the same line.
  - A lone requester is always granted.
- `*_res_addr` returns the latched address unmodified. `*_res_data` holds its value until the next response on that side.

## Timing
- Reset values:
  - State is IDLE and all slots are invalid.
  - `last_d`=1, so the I side wins the first tie.
  - All outputs (`i_res`, `d_res`, `mem_req`, `mem_we`, all address and data outputs) are 0.
- A request pulse in cycle c0 produces the slot valid in c1, a grant decision in c1, and `mem_req` high in c2 only (if no other traffic is present).
- If `mem_res` arrives in cycle c2+L, the response pulse occurs in c2+L+1. State is back in IDLE at c2+L+2, and the next grant is issued at the end of that cycle.
- Throughput: one transaction per L+3 cycles.
- Reset mid-transaction clears everything. A late `mem_res` then lands in IDLE and is ignored, with no spurious `i_res` or `d_res`.
- Simultaneous `i_read`, `d_read` and `d_wenable` from reset produce the grant order IR, DW, IR (if re-requested), DR.

## Structure
- `defines.sv` holds the FSM state encoding (`ARB_IDLE`, `ARB_WAIT`, `ARB_RESP`) and the winner IDs (`ARB_IR`, `ARB_DR`, `ARB_DW`).
- One sub-module, `mem_req_slot`, is instantiated three times. It contains the valid flag, address and data registers and the set/clear/drop logic, with the data width parameterised; the IR and DR instances may leave the data unused.
- `soc` instantiates `mem_arbiter` between `core` and `memory`. `memory` gains a single `mem_*` port.

## Test plan
- After reset, a single `i_read` at 0x100 with a memory stub of L=3 returns `i_res` 6 cycles after the pulse, with `i_res_addr`=0x100, the stub data, and exactly one `mem_req`.
- `d_wenable` at 0x40 and `d_read` at 0x40 in the same cycle produce the write command first (`mem_we`=1), then the read. `d_res_data` equals the written line, and no `d_res` is raised for the write.
- Simultaneous `i_read`, `d_read` and `d_wenable` from reset produce the grant order IR, DW, DR. Continuous I re-requests then alternate I and D, with no starvation over 20 transactions.
- A second `d_read` while DR is pending is dropped. Exactly one `d_res` is returned, with the first address.
- Asserting `rst` during WAIT and then pulsing `mem_res` produces no response and no `mem_req`. All outputs are 0 in the cycle after reset.
- A new `i_read` pulse in the same cycle the IR slot clears in RESP is kept: a second `mem_req` is issued.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and winner IDs for the memory arbiter
package mem_arbiter_pkg;
    localparam int WORD_SIZE = 32;
    localparam int LINE_SIZE = 128;
    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic [1:0] {ARB_IR, ARB_DR, ARB_DW} arb_win_t;
endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: one pending-request slot holding a valid flag and a latched payload
// Ports: clk, rst; set (request pulse) with set_val (payload to latch);
//        clr (winner retired); valid / val (slot contents).
module mem_req_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set,
    input  logic         clr,
    input  logic [W-1:0] set_val,
    output logic         valid,
    output logic [W-1:0] val
);
    // A pulse into an occupied slot is dropped unless the slot is retiring this cycle.
    logic load;
    assign load = set && (!valid || clr);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            val   <= '0;
        end else begin
            valid <= load || (valid && !clr);
            if (load) val <= set_val;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D arbiter serialising line reads and writebacks onto one memory port
// Ports: clk, rst; I read request (i_read, i_addr) and response (i_res, i_res_data, i_res_addr);
//        D read request (d_read, d_addr) and response (d_res, d_res_data, d_res_addr);
//        D writeback (d_wenable, d_w_data, d_w_addr); memory command (mem_req, mem_we,
//        mem_addr, mem_wdata) and completion (mem_res, mem_res_data).
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_res,
    output logic [LINE_SIZE-1:0] i_res_data,
    output logic [WORD_SIZE-1:0] i_res_addr,
    input  logic                 d_read,
    input  logic [WORD_SIZE-1:0] d_addr,
    output logic                 d_res,
    output logic [LINE_SIZE-1:0] d_res_data,
    output logic [WORD_SIZE-1:0] d_res_addr,
    input  logic                 d_wenable,
    input  logic [LINE_SIZE-1:0] d_w_data,
    input  logic [WORD_SIZE-1:0] d_w_addr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [LINE_SIZE-1:0] mem_wdata,
    input  logic                 mem_res,
    input  logic [LINE_SIZE-1:0] mem_res_data
);
    logic                           ir_v, dr_v, dw_v, last_d, take_d, resp;
    logic [WORD_SIZE-1:0]           ir_a, dr_a;
    logic [WORD_SIZE+LINE_SIZE-1:0] dw_p;
    arb_state_t                     state;
    arb_win_t                       win, nxt;
    assign resp = state == ARB_RESP;
    // D side wins when it alone is asking, or on a tie when I went last.
    assign take_d = (dr_v || dw_v) && !(ir_v && last_d);
    // Writeback precedes a read so a read never overtakes a dirty line.
    assign nxt = take_d ? (dw_v ? ARB_DW : ARB_DR) : ARB_IR;
    mem_req_slot #(.W(WORD_SIZE)) u_ir (
        .clk(clk), .rst(rst), .set(i_read), .clr(resp && win == ARB_IR),
        .set_val(i_addr), .valid(ir_v), .val(ir_a)
    );
    mem_req_slot #(.W(WORD_SIZE)) u_dr (
        .clk(clk), .rst(rst), .set(d_read), .clr(resp && win == ARB_DR),
        .set_val(d_addr), .valid(dr_v), .val(dr_a)
    );
    mem_req_slot #(.W(WORD_SIZE + LINE_SIZE)) u_dw (
        .clk(clk), .rst(rst), .set(d_wenable), .clr(resp && win == ARB_DW),
        .set_val({d_w_addr, d_w_data}), .valid(dw_v), .val(dw_p)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            win        <= ARB_IR;
            last_d     <= 1'b1;
            i_res      <= 1'b0;
            i_res_data <= '0;
            i_res_addr <= '0;
            d_res      <= 1'b0;
            d_res_data <= '0;
            d_res_addr <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            i_res   <= 1'b0;
            d_res   <= 1'b0;
            mem_req <= 1'b0;
            case (state)
                ARB_IDLE: if (ir_v || dr_v || dw_v) begin
                    win       <= nxt;
                    last_d    <= take_d;
                    mem_req   <= 1'b1;
                    mem_we    <= nxt == ARB_DW;
                    mem_addr  <= nxt == ARB_DW ? dw_p[WORD_SIZE+LINE_SIZE-1 -: WORD_SIZE] :
                                 nxt == ARB_DR ? dr_a : ir_a;
                    mem_wdata <= nxt == ARB_DW ? dw_p[LINE_SIZE-1:0] : '0;
                    state     <= ARB_WAIT;
                end
                ARB_WAIT: if (mem_res) begin
                    i_res <= win == ARB_IR;
                    d_res <= win == ARB_DR;
                    if (win == ARB_IR) begin
                        i_res_data <= mem_res_data;
                        i_res_addr <= ir_a;
                    end
                    if (win == ARB_DR) begin
                        d_res_data <= mem_res_data;
                        d_res_addr <= dr_a;
                    end
                    state <= ARB_RESP;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
